aes_word_stream_if: RTL and testbench
=====================================

// Module: aes_word_stream_if
// PURPOSE
//  Stream adapter directly upstream/downstream of the aes_top core.
//  Accepts 32-bit words over a valid/ready input port, assembles a 128-bit
//  key and a 128-bit text block, and pulses START with ENCDEC to the core.
//  Captures TEXTOUT on DONE and returns it as four 32-bit words over a
//  valid/ready output port. The key persists across blocks until reloaded.
// PARAMETERS
//  TIMEOUT_CYCLES  64  max cycles in WAIT for AES_DONE; 0 = no timeout
// PORTS
//  CLK          in   1    clock, all logic on rising edge
//  RST          in   1    reset, asynchronous, active-high
//  IN_VALID     in   1    input word valid
//  IN_READY     out  1    input word accepted when IN_VALID&&IN_READY
//  IN_DATA      in   32   input word
//  IN_SEL       in   1    0: text word, 1: key word
//  IN_DEC       in   1    0: encrypt, 1: decrypt; sampled with 4th text word
//  AES_START    out  1    one-cycle start pulse to core
//  AES_ENCDEC   out  1    mode to core, stable from ISSUE until DONE/timeout
//  AES_KEY      out  128  assembled key
//  AES_TEXTIN   out  128  assembled text block
//  AES_DONE     in   1    core completion pulse
//  AES_TEXTOUT  in   128  core result, valid in the AES_DONE cycle
//  OUT_VALID    out  1    result word valid
//  OUT_READY    in   1    downstream accepts when OUT_VALID&&OUT_READY
//  OUT_DATA     out  32   result word
//  KEY_VALID    out  1    full key loaded
//  TIMEOUT      out  1    one-cycle pulse: core did not answer in time
// BEHAVIOUR
//  Reset: state=LOAD; all outputs 0; key/text regs 0; word counters 0.
//  Word order: 1st word -> bits [127:96], 4th word -> bits [31:0] (both ports).
//  FSM: LOAD -> ISSUE -> WAIT -> DRAIN -> LOAD.
//  LOAD: IN_READY=1 except IN_SEL=0 && txt_cnt==3 && !KEY_VALID (holds 4th
//   text word until key ready). Key and text counters are independent (2b
//   each, wrap 3->0); words may interleave. First key word of a group clears
//   KEY_VALID; 4th key word sets it next cycle. 4th text word accepted ->
//   latch IN_DEC into AES_ENCDEC, go ISSUE.
//  ISSUE: AES_START=1 for exactly one cycle, IN_READY=0; go WAIT.
//  WAIT: IN_READY=0; cycle counter from 0. AES_DONE=1 -> capture AES_TEXTOUT,
//   go DRAIN. If TIMEOUT_CYCLES!=0 and counter reaches TIMEOUT_CYCLES-1
//   without AES_DONE -> TIMEOUT=1 one cycle, text discarded, go LOAD.
//   AES_DONE in the final timeout cycle wins (captured, no TIMEOUT).
//  AES_DONE outside WAIT is ignored.
//  DRAIN: OUT_VALID=1, OUT_DATA=word[out_cnt]; holds stable while !OUT_READY.
//   Each handshake advances out_cnt; after 4th handshake OUT_VALID=0 next
//   cycle, go LOAD. IN_READY=0 throughout DRAIN.
//  Latency: 4th text accept -> AES_START next cycle; AES_DONE -> OUT_VALID
//   next cycle. Back-to-back blocks: LOAD re-entered right after last beat.
//  Key regs are not modified outside LOAD; AES_KEY stable during WAIT.
//  RST mid-operation: immediate return to reset values, KEY_VALID=0, any
//   partial block or pending output lost.
// TESTING
//  1. FIPS-197 key 000102..0f, pt 00112233..ff, IN_DEC=0 -> one AES_START;
//     OUT words 69c4e0d8,6a7b0430,d8cdb780,70b4c55a.
//  2. Same key, ct 69c4e0d8..c55a, IN_DEC=1 -> OUT 00112233,44556677,
//     8899aabb,ccddeeff; key not reloaded between tests 1 and 2.
//  3. 4 text words with no key since reset -> IN_READY=0 on 4th word, no
//     AES_START; load key -> 4th word accepted, START follows.
//  4. Core stub never asserts DONE -> TIMEOUT pulse at WAIT cycle 63, state
//     LOAD, OUT_VALID never set.
//  5. OUT_READY toggled 1,0,0,1,... -> OUT_DATA stable while stalled, exactly
//     4 beats in order, no IN_READY until done.
//  6. RST asserted in WAIT and in DRAIN beat 2 -> all outputs 0 same cycle,
//     KEY_VALID=0, no stray OUT_VALID after release.

Source files
------------

// File: rtl/aes_word_stream_if.sv
// Word-stream adapter around the aes_top core: packs 32-bit input words into key/text
// blocks, launches the core, and serialises the 128-bit result back out as four words.
module aes_word_stream_if #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [31:0]  IN_DATA,
  input  logic         IN_SEL,
  input  logic         IN_DEC,
  output logic         AES_START,
  output logic         AES_ENCDEC,
  output logic [127:0] AES_KEY,
  output logic [127:0] AES_TEXTIN,
  input  logic         AES_DONE,
  input  logic [127:0] AES_TEXTOUT,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [31:0]  OUT_DATA,
  output logic         KEY_VALID,
  output logic         TIMEOUT
);

  typedef enum logic [1:0] {
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t       state;
  state_t       next_state;

  logic [127:0] key_reg;
  logic [127:0] text_reg;
  logic [127:0] result_reg;
  logic [1:0]   key_cnt;
  logic [1:0]   txt_cnt;
  logic [1:0]   out_cnt;
  logic [31:0]  wait_cnt;
  logic         key_valid;
  logic         encdec;

  logic         in_ready;
  logic         key_acc;
  logic         txt_acc;
  logic         out_acc;
  logic         capture;
  logic         start;
  logic         timeout;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_LOAD;
    else     state <= next_state;
  end

  // The 4th text word is held off until a full key exists, so a block never
  // launches against a partially loaded key.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    key_acc    = 1'b0;
    txt_acc    = 1'b0;
    out_acc    = 1'b0;
    capture    = 1'b0;
    start      = 1'b0;
    timeout    = 1'b0;
    case (state)
      S_LOAD: begin
        in_ready = !(!IN_SEL && (txt_cnt == 2'd3) && !key_valid);
        key_acc  = IN_VALID && in_ready && IN_SEL;
        txt_acc  = IN_VALID && in_ready && !IN_SEL;
        if (txt_acc && (txt_cnt == 2'd3)) next_state = S_ISSUE;
      end
      S_ISSUE: begin
        start      = 1'b1;
        next_state = S_WAIT;
      end
      S_WAIT: begin
        if (AES_DONE) begin
          capture    = 1'b1;
          next_state = S_DRAIN;
        end else if ((TIMEOUT_CYCLES != 0) && (wait_cnt == TIMEOUT_CYCLES - 1)) begin
          timeout    = 1'b1;
          next_state = S_LOAD;
        end
      end
      S_DRAIN: begin
        out_acc = OUT_READY;
        if (OUT_READY && (out_cnt == 2'd3)) next_state = S_LOAD;
      end
      default: next_state = S_LOAD;
    endcase
  end

  // Word n of a group lands at bits [127-32n -: 32]; ~cnt selects that slot.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      key_reg    <= '0;
      text_reg   <= '0;
      result_reg <= '0;
      key_cnt    <= '0;
      txt_cnt    <= '0;
      out_cnt    <= '0;
      wait_cnt   <= '0;
      key_valid  <= 1'b0;
      encdec     <= 1'b0;
    end else begin
      if (key_acc) begin
        key_reg[{~key_cnt, 5'd0} +: 32] <= IN_DATA;
        key_cnt <= key_cnt + 2'd1;
        if (key_cnt == 2'd0)      key_valid <= 1'b0;
        else if (key_cnt == 2'd3) key_valid <= 1'b1;
      end
      if (txt_acc) begin
        text_reg[{~txt_cnt, 5'd0} +: 32] <= IN_DATA;
        txt_cnt <= txt_cnt + 2'd1;
        if (txt_cnt == 2'd3) encdec <= IN_DEC;
      end
      wait_cnt <= (state == S_WAIT) ? wait_cnt + 32'd1 : 32'd0;
      if (capture) result_reg <= AES_TEXTOUT;
      if (out_acc) out_cnt <= out_cnt + 2'd1;
    end
  end

  // Ready is masked during reset so every output reads zero while RST is high.
  assign IN_READY   = in_ready && !RST;
  assign AES_START  = start;
  assign AES_ENCDEC = encdec;
  assign AES_KEY    = key_reg;
  assign AES_TEXTIN = text_reg;
  assign OUT_VALID  = (state == S_DRAIN);
  assign OUT_DATA   = (state == S_DRAIN) ? result_reg[{~out_cnt, 5'd0} +: 32] : 32'd0;
  assign KEY_VALID  = key_valid;
  assign TIMEOUT    = timeout;

endmodule

// File: tb/tb_aes_word_stream_if.sv
// Self-checking bench for aes_word_stream_if: a table of full blocks plus
// directed sequences for key hold-off, timeout, stalls and mid-operation reset.
module tb_aes_word_stream_if;

  logic         CLK = 1'b0;
  logic         RST;
  logic         IN_VALID;
  logic         IN_READY;
  logic [31:0]  IN_DATA;
  logic         IN_SEL;
  logic         IN_DEC;
  logic         AES_START;
  logic         AES_ENCDEC;
  logic [127:0] AES_KEY;
  logic [127:0] AES_TEXTIN;
  logic         AES_DONE;
  logic [127:0] AES_TEXTOUT;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [31:0]  OUT_DATA;
  logic         KEY_VALID;
  logic         TIMEOUT;

  int passCount  = 0;
  int checkCount = 0;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  typedef struct {
    logic         loadKey;
    logic [127:0] key;
    logic [127:0] text;
    logic         dec;
    int           delay;
    logic [127:0] coreOut;
    logic [127:0] expOut;
    logic [7:0]   readyPat;
  } vec_t;

  vec_t vecs[3];

  aes_word_stream_if #(.TIMEOUT_CYCLES(64)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .IN_DATA    (IN_DATA),
    .IN_SEL     (IN_SEL),
    .IN_DEC     (IN_DEC),
    .AES_START  (AES_START),
    .AES_ENCDEC (AES_ENCDEC),
    .AES_KEY    (AES_KEY),
    .AES_TEXTIN (AES_TEXTIN),
    .AES_DONE   (AES_DONE),
    .AES_TEXTOUT(AES_TEXTOUT),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .OUT_DATA   (OUT_DATA),
    .KEY_VALID  (KEY_VALID),
    .TIMEOUT    (TIMEOUT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_in_ready"},  IN_READY,   0);
    checkOutput({tag, "_out_valid"}, OUT_VALID,  0);
    checkOutput({tag, "_out_data"},  OUT_DATA,   0);
    checkOutput({tag, "_key_valid"}, KEY_VALID,  0);
    checkOutput({tag, "_start"},     AES_START,  0);
    checkOutput({tag, "_timeout"},   TIMEOUT,    0);
    checkOutput({tag, "_encdec"},    AES_ENCDEC, 0);
    checkOutput({tag, "_key"},       AES_KEY,    0);
    checkOutput({tag, "_textin"},    AES_TEXTIN, 0);
  endtask

  task automatic sendWord(input logic sel, input logic [31:0] data, input logic dec);
    int n = 0;
    @(negedge CLK);
    IN_VALID = 1'b1;
    IN_SEL   = sel;
    IN_DATA  = data;
    IN_DEC   = dec;
    #1;
    while (!IN_READY && n < 40) begin
      @(negedge CLK);
      #1;
      n++;
    end
    if (!IN_READY) checkOutput("in_ready_wait", IN_READY, 1);
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
  endtask

  task automatic loadKey(input logic [127:0] key);
    for (int i = 0; i < 4; i++) sendWord(1'b1, key[127 - 32*i -: 32], 1'b0);
  endtask

  task automatic sendText(input logic [127:0] text, input logic dec);
    for (int i = 0; i < 4; i++) sendWord(1'b0, text[127 - 32*i -: 32], dec);
  endtask

  task automatic expectIssue(input logic [127:0] key, input logic [127:0] text, input logic dec);
    @(negedge CLK);
    checkOutput("start_pulse", AES_START,  1);
    checkOutput("issue_key",   AES_KEY,    key);
    checkOutput("issue_text",  AES_TEXTIN, text);
    checkOutput("issue_mode",  AES_ENCDEC, dec);
    checkOutput("issue_ready", IN_READY,   0);
    @(negedge CLK);
    checkOutput("start_one_cycle", AES_START, 0);
  endtask

  task automatic coreRespond(input logic [127:0] result, input int delay);
    for (int d = 0; d < delay; d++) @(negedge CLK);
    AES_DONE    = 1'b1;
    AES_TEXTOUT = result;
    #1;
    checkOutput("no_timeout_with_done", TIMEOUT, 0);
    @(posedge CLK);
    #1;
    AES_DONE    = 1'b0;
    AES_TEXTOUT = '0;
  endtask

  task automatic drainBlock(input logic [127:0] expOut, input logic [7:0] readyPat);
    int beat = 0;
    int cyc  = 0;
    while (beat < 4 && cyc < 32) begin
      @(negedge CLK);
      OUT_READY = readyPat[cyc % 8];
      #1;
      checkOutput("drain_valid", OUT_VALID, 1);
      checkOutput($sformatf("drain_word%0d", beat), OUT_DATA, expOut[127 - 32*beat -: 32]);
      checkOutput("drain_in_ready", IN_READY, 0);
      if (OUT_VALID && OUT_READY) beat++;
      cyc++;
    end
    if (beat < 4) checkOutput("drain_beats", beat, 4);
    @(negedge CLK);
    OUT_READY = 1'b0;
    #1;
    checkOutput("drain_end_valid", OUT_VALID, 0);
    checkOutput("drain_back_to_load", IN_READY, 1);
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.loadKey) loadKey(v.key);
    sendText(v.text, v.dec);
    expectIssue(v.key, v.text, v.dec);
    coreRespond(v.coreOut, v.delay);
    drainBlock(v.expOut, v.readyPat);
  endtask

  initial begin
    int startSeen;
    int earlyTimeout;
    int strayValid;

    vecs[0] = '{1'b1, FIPS_KEY, FIPS_PT, 1'b0, 3, FIPS_CT, FIPS_CT, 8'hFF};
    vecs[1] = '{1'b0, FIPS_KEY, FIPS_CT, 1'b1, 1, FIPS_PT, FIPS_PT, 8'hFF};
    vecs[2] = '{1'b1, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3243f6a8885a308d313198a2e0370734, 1'b0, 5,
                128'h3925841d02dc09fbdc118597196a0b32,
                128'h3925841d02dc09fbdc118597196a0b32, 8'b10011001};

    RST         = 1'b0;
    IN_VALID    = 1'b0;
    IN_DATA     = '0;
    IN_SEL      = 1'b0;
    IN_DEC      = 1'b0;
    AES_DONE    = 1'b0;
    AES_TEXTOUT = '0;
    OUT_READY   = 1'b0;
    #1 RST = 1'b1;
    #1 checkResetState("reset");
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1 checkOutput("after_reset_ready", IN_READY, 1);

    $display("[TB] text before key: 4th word must be held");
    for (int i = 0; i < 3; i++) sendWord(1'b0, FIPS_PT[127 - 32*i -: 32], 1'b0);
    @(negedge CLK);
    IN_VALID = 1'b1;
    IN_SEL   = 1'b0;
    IN_DATA  = FIPS_PT[31:0];
    #1 checkOutput("hold_4th_text", IN_READY, 0);
    startSeen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      #1;
      if (AES_START || IN_READY) startSeen++;
    end
    checkOutput("hold_no_start", startSeen, 0);
    IN_VALID = 1'b0;
    checkOutput("hold_key_valid", KEY_VALID, 0);
    loadKey(FIPS_KEY);
    checkOutput("key_valid_set", KEY_VALID, 1);
    sendWord(1'b0, FIPS_PT[31:0], 1'b0);
    expectIssue(FIPS_KEY, FIPS_PT, 1'b0);
    coreRespond(FIPS_CT, 2);
    drainBlock(FIPS_CT, 8'hFF);

    $display("[TB] table vectors");
    for (int i = 0; i < 3; i++) applyStimulus(vecs[i]);

    $display("[TB] done pulse outside WAIT is ignored");
    @(negedge CLK);
    AES_DONE    = 1'b1;
    AES_TEXTOUT = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    @(negedge CLK);
    AES_DONE    = 1'b0;
    AES_TEXTOUT = '0;
    #1;
    checkOutput("stray_done_valid", OUT_VALID, 0);
    checkOutput("stray_done_ready", IN_READY, 1);

    $display("[TB] core never answers");
    sendText(FIPS_PT, 1'b0);
    expectIssue(vecs[2].key, FIPS_PT, 1'b0);
    earlyTimeout = 0;
    strayValid   = 0;
    for (int k = 0; k < 63; k++) begin
      if (k > 0) @(negedge CLK);
      #1;
      if (TIMEOUT) earlyTimeout++;
      if (OUT_VALID) strayValid++;
    end
    @(negedge CLK);
    #1;
    checkOutput("timeout_at_63", TIMEOUT, 1);
    checkOutput("timeout_early", earlyTimeout, 0);
    checkOutput("timeout_no_valid", strayValid, 0);
    @(negedge CLK);
    #1;
    checkOutput("timeout_single", TIMEOUT, 0);
    checkOutput("timeout_out_valid", OUT_VALID, 0);
    checkOutput("timeout_to_load", IN_READY, 1);

    $display("[TB] done in final timeout cycle wins");
    sendText(FIPS_CT, 1'b1);
    expectIssue(vecs[2].key, FIPS_CT, 1'b1);
    coreRespond(FIPS_PT, 63);
    drainBlock(FIPS_PT, 8'hFF);

    $display("[TB] reset while waiting on the core");
    sendText(FIPS_PT, 1'b0);
    expectIssue(vecs[2].key, FIPS_PT, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    #1 checkResetState("rst_wait");
    @(negedge CLK);
    RST = 1'b0;
    strayValid = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      #1;
      if (OUT_VALID || AES_START) strayValid++;
    end
    checkOutput("rst_wait_no_stray", strayValid, 0);
    checkOutput("rst_wait_key_valid", KEY_VALID, 0);

    $display("[TB] reset during drain beat 2");
    loadKey(FIPS_KEY);
    sendText(FIPS_PT, 1'b0);
    expectIssue(FIPS_KEY, FIPS_PT, 1'b0);
    coreRespond(FIPS_CT, 0);
    @(negedge CLK);
    OUT_READY = 1'b1;
    #1 checkOutput("rst_drain_w0", OUT_DATA, FIPS_CT[127:96]);
    @(negedge CLK);
    #1 checkOutput("rst_drain_w1", OUT_DATA, FIPS_CT[95:64]);
    @(negedge CLK);
    OUT_READY = 1'b0;
    #1;
    checkOutput("rst_drain_w2_valid", OUT_VALID, 1);
    checkOutput("rst_drain_w2", OUT_DATA, FIPS_CT[63:32]);
    RST = 1'b1;
    #1 checkResetState("rst_drain");
    @(negedge CLK);
    RST = 1'b0;
    strayValid = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      OUT_READY = 1'b1;
      #1;
      if (OUT_VALID) strayValid++;
    end
    OUT_READY = 1'b0;
    checkOutput("rst_drain_no_stray", strayValid, 0);
    checkOutput("rst_drain_key_valid", KEY_VALID, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
